// File: rtl/mem_access_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// mem_access_pkg - shared types and default address map for mem_access_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
package mem_access_pkg;

  localparam logic [15:0] C_ROM_BASE        = 16'hD000;
  localparam logic [15:0] C_FB_BASE         = 16'hE000;
  localparam logic [15:0] C_EXT_KERNEL_ADDR = 16'h8004;
  localparam logic [15:0] C_EXT_USER_ADDR   = 16'h8800;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAM_ISSUE = 3'd1,
    ST_RAM_WAIT  = 3'd2,
    ST_ROM_WAIT  = 3'd3,
    ST_CFG       = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM   = 3'd0,
    TGT_ROM   = 3'd1,
    TGT_FB    = 3'd2,
    TGT_EXT_K = 3'd3,
    TGT_EXT_U = 3'd4,
    TGT_NONE  = 3'd5
  } tgt_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_TIMEOUT    = 3'd1,
    ERR_UNMAPPED   = 3'd2,
    ERR_READ_ONLY  = 3'd3,
    ERR_WRITE_ONLY = 3'd4
  } err_e;

  function automatic logic is_error(input err_e cause);
    return cause != ERR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// mem_access_unit_if - CPU-side request/response handshake bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface
`default_nettype wire

// File: rtl/cfg_addr_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// cfg_addr_decode - maps a CPU address to its target and region offset.
// Revision: 1.0
//------------------------------------------------------------------------------
module cfg_addr_decode
  import mem_access_pkg::*;
#(
  parameter int                DATA_W          = 16,
  parameter logic [DATA_W-1:0] ROM_BASE        = C_ROM_BASE,
  parameter int                ROM_DEPTH       = 2048,
  parameter logic [DATA_W-1:0] FB_BASE         = C_FB_BASE,
  parameter int                FB_SIZE         = 4800,
  parameter logic [DATA_W-1:0] EXT_KERNEL_ADDR = C_EXT_KERNEL_ADDR,
  parameter logic [DATA_W-1:0] EXT_USER_ADDR   = C_EXT_USER_ADDR
) (
  input  logic [DATA_W-1:0]            addr_i,
  output tgt_e                         tgt_o,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_off_o,
  output logic [$clog2(FB_SIZE)-1:0]   fb_off_o
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int FB_AW  = $clog2(FB_SIZE);

  // One extra bit keeps the region end from wrapping at the top of the map.
  localparam logic [DATA_W:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [DATA_W:0] ROM_HI = ROM_LO + (DATA_W+1)'(ROM_DEPTH);
  localparam logic [DATA_W:0] FB_LO  = {1'b0, FB_BASE};
  localparam logic [DATA_W:0] FB_HI  = FB_LO + (DATA_W+1)'(FB_SIZE);

  logic [DATA_W:0] addr_ext;

  assign addr_ext  = {1'b0, addr_i};
  assign rom_off_o = ROM_AW'(addr_i - ROM_BASE);
  assign fb_off_o  = FB_AW'(addr_i - FB_BASE);

  always_comb begin
    tgt_o = TGT_NONE;
    if (!addr_i[DATA_W-1]) begin
      tgt_o = TGT_RAM;
    end else if (addr_i == EXT_KERNEL_ADDR) begin
      tgt_o = TGT_EXT_K;
    end else if (addr_i == EXT_USER_ADDR) begin
      tgt_o = TGT_EXT_U;
    end else if (addr_ext >= ROM_LO && addr_ext < ROM_HI) begin
      tgt_o = TGT_ROM;
    end else if (addr_ext >= FB_LO && addr_ext < FB_HI) begin
      tgt_o = TGT_FB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// mem_access_unit - single-outstanding load/store unit for SDRAM/ROM/FB/ext regs.
// Revision: 1.0
//------------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                DATA_W          = 16,
  parameter int                EXT_W           = 5,
  parameter logic [DATA_W-1:0] ROM_BASE        = C_ROM_BASE,
  parameter int                ROM_DEPTH       = 2048,
  parameter logic [DATA_W-1:0] FB_BASE         = C_FB_BASE,
  parameter int                FB_SIZE         = 4800,
  parameter logic [DATA_W-1:0] EXT_KERNEL_ADDR = C_EXT_KERNEL_ADDR,
  parameter logic [DATA_W-1:0] EXT_USER_ADDR   = C_EXT_USER_ADDR,
  parameter int                TIMEOUT         = 255,
  localparam int               RAM_ADDR_W      = 2*EXT_W + DATA_W - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_access_unit_if.slave             bus,
  output logic [RAM_ADDR_W-1:0]        ram_rd_addr_o,
  output logic [RAM_ADDR_W-1:0]        ram_wr_addr_o,
  output logic [DATA_W-1:0]            ram_wr_data_o,
  output logic                         ram_rd_en_o,
  output logic                         ram_wr_en_o,
  input  logic [DATA_W-1:0]            ram_rd_data_i,
  input  logic                         ram_rd_ready_i,
  input  logic                         ram_busy_i,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]            rom_data_i,
  output logic [$clog2(FB_SIZE)-1:0]   fb_addr_o,
  output logic [7:0]                   fb_data_o,
  output logic                         fb_we_o,
  output logic [EXT_W-1:0]             ext_kernel_o,
  output logic [EXT_W-1:0]             ext_user_o
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int FB_AW  = $clog2(FB_SIZE);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int CW     = (EXT_W > 8) ? EXT_W : 8;

  state_e                state_q, state_d;
  tgt_e                  tgt_q, tgt_d;
  logic                  write_q, write_d;
  logic [CW-1:0]         cfg_wdata_q, cfg_wdata_d;
  logic [FB_AW-1:0]      fb_off_q, fb_off_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EXT_W-1:0]      ext_k_q, ext_k_d, ext_u_q, ext_u_d;
  logic [RAM_ADDR_W-1:0] ram_rd_addr_q, ram_rd_addr_d, ram_wr_addr_q, ram_wr_addr_d;
  logic [DATA_W-1:0]     ram_wr_data_q, ram_wr_data_d;
  logic                  ram_rd_en_q, ram_rd_en_d, ram_wr_en_q, ram_wr_en_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic [FB_AW-1:0]      fb_addr_q, fb_addr_d;
  logic [7:0]            fb_data_q, fb_data_d;
  logic                  fb_we_q, fb_we_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic                  rom_resp_q, rom_resp_d;
  err_e                  err_cause;

  tgt_e                  dec_tgt;
  logic [ROM_AW-1:0]     dec_rom_off;
  logic [FB_AW-1:0]      dec_fb_off;

  cfg_addr_decode #(
    .DATA_W          (DATA_W),
    .ROM_BASE        (ROM_BASE),
    .ROM_DEPTH       (ROM_DEPTH),
    .FB_BASE         (FB_BASE),
    .FB_SIZE         (FB_SIZE),
    .EXT_KERNEL_ADDR (EXT_KERNEL_ADDR),
    .EXT_USER_ADDR   (EXT_USER_ADDR)
  ) u_decode (
    .addr_i    (bus.req_addr),
    .tgt_o     (dec_tgt),
    .rom_off_o (dec_rom_off),
    .fb_off_o  (dec_fb_off)
  );

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    write_d       = write_q;
    cfg_wdata_d   = cfg_wdata_q;
    fb_off_d      = fb_off_q;
    cnt_d         = cnt_q;
    ext_k_d       = ext_k_q;
    ext_u_d       = ext_u_q;
    ram_rd_addr_d = ram_rd_addr_q;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    rom_addr_d    = rom_addr_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    ram_rd_en_d   = 1'b0;
    ram_wr_en_d   = 1'b0;
    fb_we_d       = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_error_d  = 1'b0;
    rom_resp_d    = 1'b0;
    err_cause     = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (ready_q && bus.req_valid) begin
          tgt_d       = dec_tgt;
          write_d     = bus.req_write;
          cfg_wdata_d = bus.req_wdata[CW-1:0];
          fb_off_d    = dec_fb_off;
          cnt_d       = '0;
          if (dec_tgt == TGT_RAM) begin
            // Extension registers are sampled here, so a config write that
            // just completed already steers this access.
            if (bus.req_write) begin
              ram_wr_addr_d = {ext_k_q, ext_u_q, bus.req_addr[DATA_W-2:0]};
              ram_wr_data_d = bus.req_wdata;
            end else begin
              ram_rd_addr_d = {ext_k_q, ext_u_q, bus.req_addr[DATA_W-2:0]};
            end
            state_d = ST_RAM_ISSUE;
          end else if (dec_tgt == TGT_ROM && !bus.req_write) begin
            rom_addr_d = dec_rom_off;
            state_d    = ST_ROM_WAIT;
          end else begin
            state_d = ST_CFG;
          end
        end
      end

      ST_RAM_ISSUE: begin
        if (!ram_busy_i) begin
          if (write_q) begin
            ram_wr_en_d  = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            ram_rd_en_d = 1'b1;
            state_d     = ST_RAM_WAIT;
          end
        end
      end

      ST_RAM_WAIT: begin
        // Returning data takes priority over an expiring timeout.
        if (ram_rd_ready_i) begin
          resp_rdata_d = ram_rd_data_i;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_cause    = ERR_TIMEOUT;
            resp_error_d = is_error(err_cause);
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end

      ST_ROM_WAIT: begin
        rom_resp_d   = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_CFG: begin
        unique case (tgt_q)
          TGT_EXT_K: begin
            if (write_q) ext_k_d = cfg_wdata_q[EXT_W-1:0];
            else         resp_rdata_d = DATA_W'(ext_k_q);
          end
          TGT_EXT_U: begin
            if (write_q) ext_u_d = cfg_wdata_q[EXT_W-1:0];
            else         resp_rdata_d = DATA_W'(ext_u_q);
          end
          TGT_FB: begin
            if (write_q) begin
              fb_we_d   = 1'b1;
              fb_addr_d = fb_off_q;
              fb_data_d = cfg_wdata_q[7:0];
            end else begin
              err_cause = ERR_WRITE_ONLY;
            end
          end
          TGT_ROM:  err_cause = ERR_READ_ONLY;
          default:  err_cause = ERR_UNMAPPED;
        endcase
        resp_error_d = is_error(err_cause);
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tgt_q         <= TGT_NONE;
      write_q       <= 1'b0;
      cfg_wdata_q   <= '0;
      fb_off_q      <= '0;
      cnt_q         <= '0;
      ext_k_q       <= '0;
      ext_u_q       <= '0;
      ram_rd_addr_q <= '0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      ram_rd_en_q   <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      rom_addr_q    <= '0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      fb_we_q       <= 1'b0;
      ready_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
      rom_resp_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      write_q       <= write_d;
      cfg_wdata_q   <= cfg_wdata_d;
      fb_off_q      <= fb_off_d;
      cnt_q         <= cnt_d;
      ext_k_q       <= ext_k_d;
      ext_u_q       <= ext_u_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_rd_en_q   <= ram_rd_en_d;
      ram_wr_en_q   <= ram_wr_en_d;
      rom_addr_q    <= rom_addr_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      fb_we_q       <= fb_we_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      rom_resp_q    <= rom_resp_d;
    end
  end

  // The synchronous ROM presents its word during the response cycle itself.
  assign bus.resp_rdata = rom_resp_q ? rom_data_i : resp_rdata_q;
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;

  assign ram_rd_addr_o = ram_rd_addr_q;
  assign ram_wr_addr_o = ram_wr_addr_q;
  assign ram_wr_data_o = ram_wr_data_q;
  assign ram_rd_en_o   = ram_rd_en_q;
  assign ram_wr_en_o   = ram_wr_en_q;
  assign rom_addr_o    = rom_addr_q;
  assign fb_addr_o     = fb_addr_q;
  assign fb_data_o     = fb_data_q;
  assign fb_we_o       = fb_we_q;
  assign ext_kernel_o  = ext_k_q;
  assign ext_user_o    = ext_u_q;

endmodule
`default_nettype wire
